fadd_share_ctrl: RTL and testbench

//  Shares one fixed-latency FP add/sub datapath (far/near-path adder plus its

---
 rtl/fadd_share_ctrl.sv | 159 +++++++++++++++
 tb/tb_fadd_share_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_share_ctrl.sv
// fadd_share_ctrl
//   Shares one fixed-latency FP add/sub datapath between NUM_REQ requesters.
//   A round-robin arbiter issues at most one op per cycle. A LAT-deep ID pipe
//   follows each op through the adder, and results land in a response FIFO.
//   Issue is gated by a credit count, so the FIFO can never overflow and the
//   adder never needs a stall.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o   per-requester op handshake
//   req_a_i, req_b_i            packed operands, slot i = [i*DATA_W +: DATA_W]
//   req_sub_i, req_rm_i         per-requester subtract flag / rounding mode
//   add_valid_o, add_*_o        issue strobe and fields to the adder
//   add_res_valid_i, add_res_i, add_fflags_i   adder result, LAT cycles after issue
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_data_o, rsp_fflags_o, rsp_id_o   response payload and originating requester
//   busy_o                      ops in flight or buffered
//   err_o                       sticky: adder result valid disagreed with the ID pipe
//
// Handshake rule: a transfer happens on a rising edge where valid & ready are
// both 1. A response stays stable while valid is 1 and ready is 0.
module fadd_share_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int LAT     = 3,
   parameter int DEPTH   = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
   input  logic [NUM_REQ-1:0]          req_sub_i,
   input  logic [NUM_REQ*3-1:0]        req_rm_i,
   output logic                        add_valid_o,
   output logic [DATA_W-1:0]           add_a_o,
   output logic [DATA_W-1:0]           add_b_o,
   output logic                        add_sub_o,
   output logic [2:0]                  add_rm_o,
   input  logic                        add_res_valid_i,
   input  logic [DATA_W-1:0]           add_res_i,
   input  logic [4:0]                  add_fflags_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [DATA_W-1:0]           rsp_data_o,
   output logic [4:0]                  rsp_fflags_o,
   output logic [ID_W-1:0]             rsp_id_o,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = ID_W + 5 + DATA_W;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt_idx;
   logic            gnt_any;
   logic            credit_ok;
   logic            fire;
   logic            push;
   logic            pop;
   logic            pipe_err;
   logic [CW-1:0]   credit;
   logic            pipe_vld [LAT];
   logic [ID_W-1:0] pipe_id  [LAT];
   logic [PW:0]     wr_ptr;
   logic [PW:0]     rd_ptr;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   head;

   // Round-robin scan starting at rr_ptr.
   always_comb begin : arb
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_any && req_valid_i[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'(idx);
         end
      end
   end

   // rst_n is folded in so every output reads 0 while reset is held.
   assign credit_ok   = credit < CW'(DEPTH);
   assign fire        = rst_n & gnt_any & credit_ok;
   assign add_valid_o = fire;
   assign req_ready_o = fire ? (NUM_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      add_a_o   = '0;
      add_b_o   = '0;
      add_sub_o = 1'b0;
      add_rm_o  = '0;
      if (fire) begin
         add_a_o   = req_a_i[int'(gnt_idx)*DATA_W +: DATA_W];
         add_b_o   = req_b_i[int'(gnt_idx)*DATA_W +: DATA_W];
         add_sub_o = req_sub_i[gnt_idx];
         add_rm_o  = req_rm_i[int'(gnt_idx)*3 +: 3];
      end
   end

   // The ID pipe mirrors the adder's latency. The result is pushed only when
   // both agree that a result is due. Any disagreement is a protocol error.
   assign push     = pipe_vld[LAT-1] & add_res_valid_i;
   assign pipe_err = pipe_vld[LAT-1] ^ add_res_valid_i;

   assign rsp_valid_o = (wr_ptr != rd_ptr);
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign busy_o      = (credit != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         credit <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         err_o  <= 1'b0;
         for (int i = 0; i < LAT; i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_id[i]  <= '0;
         end
      end else begin
         if (fire)
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         case ({fire, pop})
            2'b10:   credit <= credit + CW'(1);
            2'b01:   credit <= credit - CW'(1);
            default: credit <= credit;
         endcase
         pipe_vld[0] <= fire;
         pipe_id[0]  <= gnt_idx;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_id[i]  <= pipe_id[i-1];
         end
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
         if (pipe_err) err_o <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[PW-1:0]] <= {pipe_id[LAT-1], add_fflags_i, add_res_i};
   end

   assign head         = mem[rd_ptr[PW-1:0]];
   assign rsp_data_o   = rsp_valid_o ? head[DATA_W-1:0]      : '0;
   assign rsp_fflags_o = rsp_valid_o ? head[DATA_W +: 5]     : '0;
   assign rsp_id_o     = rsp_valid_o ? head[DATA_W+5 +: ID_W] : '0;

endmodule

// File: tb/tb_fadd_share_ctrl.sv
module tb_fadd_share_ctrl;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int LAT     = 3;
  localparam int DEPTH   = 4;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int W       = ID_W + 5 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;
  logic [NUM_REQ*3-1:0]      req_rm;
  logic                      add_valid;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic                      add_sub;
  logic [2:0]                add_rm;
  logic                      add_res_valid;
  logic [DATA_W-1:0]         add_res;
  logic [4:0]                add_fflags;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [4:0]                rsp_fflags;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;
  logic                      err;

  logic [DATA_W-1:0] op_a   [NUM_REQ];
  logic [DATA_W-1:0] op_b   [NUM_REQ];
  logic              op_sub [NUM_REQ];
  logic [2:0]        op_rm  [NUM_REQ];
  logic              inj_res;

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_sub = '0;
    req_rm  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = op_a[i];
      req_b[i*DATA_W +: DATA_W] = op_b[i];
      req_sub[i]                = op_sub[i];
      req_rm[i*3 +: 3]          = op_rm[i];
    end
  end

  fadd_share_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub), .req_rm_i(req_rm),
    .add_valid_o(add_valid), .add_a_o(add_a), .add_b_o(add_b),
    .add_sub_o(add_sub), .add_rm_o(add_rm),
    .add_res_valid_i(add_res_valid), .add_res_i(add_res), .add_fflags_i(add_fflags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_fflags_o(rsp_fflags), .rsp_id_o(rsp_id),
    .busy_o(busy), .err_o(err)
  );

  // ---------------- adder stand-in (fixed LAT, reset with the block) ----------------
  logic              rp_v   [LAT];
  logic [DATA_W-1:0] rp_res [LAT];
  logic [4:0]        rp_fl  [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        rp_v[i] <= 1'b0; rp_res[i] <= '0; rp_fl[i] <= '0;
      end
    end else begin
      rp_v[0]   <= add_valid;
      rp_res[0] <= add_sub ? add_a - add_b : add_a + add_b;
      rp_fl[0]  <= {add_rm, add_sub, add_a[0]};
      for (int i = 1; i < LAT; i++) begin
        rp_v[i] <= rp_v[i-1]; rp_res[i] <= rp_res[i-1]; rp_fl[i] <= rp_fl[i-1];
      end
    end
  end

  assign add_res_valid = rp_v[LAT-1] | inj_res;
  assign add_res       = rp_res[LAT-1];
  assign add_fflags    = rp_fl[LAT-1];

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  dut_issues = 0;
  int  m_rr = 0;
  int  m_credit = 0;
  int  m_cnt = 0;
  bit  m_err = 0;
  bit  m_pv [LAT];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_credit = 0; m_cnt = 0; m_err = 0;
    for (int i = 0; i < LAT; i++) m_pv[i] = 0;
    exp_q.delete();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i]   = $urandom;
      op_b[i]   = $urandom;
      op_sub[i] = 1'($urandom_range(0, 1));
      op_rm[i]  = 3'($urandom_range(0, 7));
    end
  endtask

  // One clock: check combinational and registered outputs against the model,
  // then advance the model across the rising edge.
  task automatic tick();
    logic [NUM_REQ-1:0] e_ready;
    logic [DATA_W-1:0]  e_data;
    logic [W-1:0]       e;
    bit found, e_fire, pop, arrive;
    int g, idx;
    #1;
    e_ready = '0; found = 0; g = 0;
    if (rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_rr + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin found = 1; g = idx; end
      end
    end
    e_fire = found && (m_credit < DEPTH);
    if (e_fire) e_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("add_valid", 64'(add_valid), 64'(e_fire));
    if (e_fire) begin
      check("add_a", 64'(add_a), 64'(op_a[g]));
      check("add_b", 64'(add_b), 64'(op_b[g]));
    end
    check("rsp_valid", 64'(rsp_valid), 64'(rst_n && m_cnt > 0));
    pop = rst_n && (m_cnt > 0) && rsp_ready;
    if (pop) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("rsp_data",   64'(rsp_data),   64'(e[DATA_W-1:0]));
      check("rsp_fflags", 64'(rsp_fflags), 64'(e[DATA_W +: 5]));
      check("rsp_id",     64'(rsp_id),     64'(e[DATA_W+5 +: ID_W]));
    end
    check("busy", 64'(busy), 64'(rst_n && m_credit != 0));
    check("err",  64'(err),  64'(rst_n && m_err));
    if (add_valid === 1'b1) dut_issues++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      arrive = m_pv[LAT-1];
      if (inj_res && !arrive) m_err = 1;
      m_cnt = m_cnt + int'(arrive) - int'(pop);
      for (int i = LAT-1; i > 0; i--) m_pv[i] = m_pv[i-1];
      m_pv[0] = e_fire;
      m_credit = m_credit + int'(e_fire) - int'(pop);
      if (e_fire) begin
        m_rr   = (g + 1) % NUM_REQ;
        e_data = op_sub[g] ? op_a[g] - op_b[g] : op_a[g] + op_b[g];
        exp_q.push_back({ID_W'(g), op_rm[g], op_sub[g], op_a[g][0], e_data});
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; inj_res = 1'b0;
    model_reset();
    rand_ops();
    @(negedge clk);

    // Reset held with both requesters asking: nothing may be accepted.
    req_valid = 2'b11;
    repeat (2) tick();
    rst_n = 1'b1; req_valid = '0;
    tick();

    // Fairness: both valid every cycle, consumer always ready.
    rsp_ready = 1'b1; req_valid = 2'b11;
    repeat (8) begin rand_ops(); tick(); end
    req_valid = '0;
    repeat (LAT + 3) tick();

    // Backpressure: consumer stalled, requester 0 holds valid.
    rsp_ready = 1'b0; req_valid = 2'b01; rand_ops(); dut_issues = 0;
    repeat (8) tick();
    check("bp_issue_count", 64'(dut_issues), 64'(DEPTH));
    dut_issues = 0;
    rsp_ready = 1'b1; tick();
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("bp_one_more", 64'(dut_issues), 64'(1));
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) tick();

    // Fire and pop together at credit DEPTH-1.
    rsp_ready = 1'b0; req_valid = 2'b10;
    repeat (3) begin rand_ops(); tick(); end
    req_valid = '0;
    repeat (LAT + 1) tick();
    req_valid = 2'b01; rsp_ready = 1'b1; rand_ops();
    tick();
    rsp_ready = 1'b0; dut_issues = 0;
    repeat (3) tick();
    check("credit_held", 64'(dut_issues), 64'(1));
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) tick();

    // Protocol error: a result with nothing in flight.
    inj_res = 1'b1; tick();
    inj_res = 1'b0;
    repeat (3) tick();

    // Reset clears the error, then reset again with ops in flight.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    rsp_ready = 1'b1; req_valid = 2'b11;
    repeat (3) begin rand_ops(); tick(); end
    req_valid = '0; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();

    // Random traffic with random backpressure.
    repeat (60) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 1'($urandom_range(0, 1));
      rand_ops();
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (10) tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
